// File: rtl/button_conditioner.sv
// button_conditioner: per-channel 2-flop synchronizer, debounce counter and
// press/release edge pulses for the board push-buttons, with optional
// auto-repeat strobes while a button is held.
// Build option: define BTN_AUTO_REPEAT_EN to build the auto-repeat FSM;
// without it btn_repeat is tied to 0 and the port is kept for wiring.
module button_conditioner #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic [N_BTN-1:0] buttons_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic             any_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0]            sync_p0;
  logic [N_BTN-1:0]            sync_p1;
  logic [N_BTN-1:0][CNT_W-1:0] cnt;
  logic [N_BTN-1:0]            accept;
  logic [N_BTN-1:0]            press_nxt;
  logic [N_BTN-1:0]            release_nxt;

  // Stage p0/p1: two-flop synchronizer bringing the raw pins into clk domain
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= buttons_raw;
      sync_p1 <= sync_p0;
    end
  end

  // A change is accepted on the edge where the counter has seen the
  // synchronized value differ from the level for DEBOUNCE_CYCLES edges
  always_comb begin
    accept = '0;
    for (int i = 0; i < N_BTN; i++) begin
      accept[i] = (sync_p1[i] != btn_level[i]) && (cnt[i] == CNT_LAST);
    end
  end

  assign press_nxt   = accept & sync_p1;
  assign release_nxt = accept & ~sync_p1;

  // Stage p2: debounce counters, registered level and edge pulses
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt         <= '0;
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      any_press   <= 1'b0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        // Agreement (including a one-cycle glitch back) restarts the count
        if ((sync_p1[i] == btn_level[i]) || accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
      btn_level   <= btn_level ^ accept;
      btn_press   <= press_nxt;
      btn_release <= release_nxt;
      any_press   <= |press_nxt;
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam int RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RC_W   = $clog2(RC_MAX) + 1;
  localparam logic [RC_W-1:0] RC_DELAY_LAST  = RC_W'(REPEAT_DELAY - 1);
  localparam logic [RC_W-1:0] RC_PERIOD_LAST = RC_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_UP,
    ST_HOLD_DELAY,
    ST_HOLD_REPEAT
  } rpt_state_t;

  rpt_state_t [N_BTN-1:0]     state;
  logic [N_BTN-1:0][RC_W-1:0] rc;

  // Stage p2: per-channel hold FSM issuing the auto-repeat strobes;
  // an accepted release wins over a repeat due on the same edge
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < N_BTN; i++) begin
        state[i] <= ST_UP;
      end
      rc         <= '0;
      btn_repeat <= '0;
    end else begin
      btn_repeat <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        case (state[i])
          ST_UP: begin
            if (press_nxt[i]) begin
              state[i] <= ST_HOLD_DELAY;
              rc[i]    <= '0;
            end
          end
          ST_HOLD_DELAY: begin
            if (release_nxt[i]) begin
              state[i] <= ST_UP;
              rc[i]    <= '0;
            end else if (rc[i] == RC_DELAY_LAST) begin
              btn_repeat[i] <= 1'b1;
              rc[i]         <= '0;
              state[i]      <= ST_HOLD_REPEAT;
            end else begin
              rc[i] <= rc[i] + RC_W'(1);
            end
          end
          ST_HOLD_REPEAT: begin
            if (release_nxt[i]) begin
              state[i] <= ST_UP;
              rc[i]    <= '0;
            end else if (rc[i] == RC_PERIOD_LAST) begin
              btn_repeat[i] <= 1'b1;
              rc[i]         <= '0;
            end else begin
              rc[i] <= rc[i] + RC_W'(1);
            end
          end
          default: begin
            state[i] <= ST_UP;
            rc[i]    <= '0;
          end
        endcase
      end
    end
  end
`else
  // Without auto-repeat the hold FSM collapses to UP/DOWN, which is
  // exactly btn_level, so no extra state is kept
  assign btn_repeat = '0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: drives button_conditioner with directed and random
// button patterns and compares every output each cycle against a sliding
// window debounce model and an arithmetic repeat-schedule model.
module tb_button_conditioner;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic         clk = 1'b0;
  logic         rst_l = 1'b0;
  logic [N-1:0] buttons_raw = '0;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic [N-1:0] btn_repeat;
  logic         any_press;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state
  logic [N-1:0] win[$];
  logic [N-1:0] exp_level, exp_press, exp_release, exp_repeat;
  logic         exp_any;
  int           cyc;
  int           press_cyc[N];

  // Scenario counters
  int n_p1, n_r2, n_rep3, n_p_any;

  button_conditioner #(
    .N_BTN          (N),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .buttons_raw(buttons_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat),
    .any_press  (any_press)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    win.delete();
    for (int j = 0; j < D + 1; j++) win.push_back('0);
    exp_level   = '0;
    exp_press   = '0;
    exp_release = '0;
    exp_repeat  = '0;
    exp_any     = 1'b0;
    cyc         = 0;
    for (int i = 0; i < N; i++) press_cyc[i] = 0;
  endtask

  // Level flips once the D samples seen by the debouncer (raw delayed by
  // two edges) all disagree with the current level.
  task automatic model_edge();
    logic [N-1:0] new_lvl;
    bit           all_diff;
    int           d;
    if (!rst_l) begin
      model_reset();
      return;
    end
    cyc++;
    win.push_back(buttons_raw);
    new_lvl = exp_level;
    for (int i = 0; i < N; i++) begin
      all_diff = 1'b1;
      for (int j = 0; j < D; j++) begin
        if (win[j][i] == exp_level[i]) all_diff = 1'b0;
      end
      if (all_diff) new_lvl[i] = ~exp_level[i];
    end
    void'(win.pop_front());
    exp_press   = new_lvl & ~exp_level;
    exp_release = ~new_lvl & exp_level;
    exp_any     = |exp_press;
    exp_repeat  = '0;
    for (int i = 0; i < N; i++) begin
      if (exp_press[i]) begin
        press_cyc[i] = cyc;
      end else if (new_lvl[i]) begin
        d = cyc - press_cyc[i];
        if (d >= RD && ((d - RD) % RP) == 0) exp_repeat[i] = 1'b1;
      end
    end
`ifndef BTN_AUTO_REPEAT_EN
    exp_repeat = '0;
`endif
    exp_level = new_lvl;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".level"},   btn_level,   exp_level);
    chk({tag, ".press"},   btn_press,   exp_press);
    chk({tag, ".release"}, btn_release, exp_release);
    chk({tag, ".repeat"},  btn_repeat,  exp_repeat);
    chk({tag, ".any"},     {3'b000, any_press}, {3'b000, exp_any});
  endtask

  // Called at a negedge: drive, clock, update model, check after the edge.
  task automatic cycle(input string tag, input logic [N-1:0] raw);
    buttons_raw = raw;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    if (btn_press[1])   n_p1++;
    if (btn_release[2]) n_r2++;
    if (btn_repeat[3])  n_rep3++;
    if (any_press)      n_p_any++;
    @(negedge clk);
  endtask

  task automatic hold(input string tag, input logic [N-1:0] raw, input int n);
    for (int k = 0; k < n; k++) cycle(tag, raw);
  endtask

  task automatic assert_reset();
    rst_l = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #1;
  endtask

  initial begin
    logic [N-1:0] r;
    model_reset();
    @(negedge clk);

    // 1. reset with all buttons held, then release
    assert_reset();
    hold("rst_hold", 4'hF, 5);
    rst_l = 1'b1;
    hold("rst_rel", 4'hF, 5);
    chk("rst_lvl_before", btn_level, 4'h0);
    cycle("rst_rel6", 4'hF);
    chk("rst_press6", btn_press, 4'hF);
    chk("rst_level6", btn_level, 4'hF);
    chk("rst_any6", {3'b000, any_press}, 4'h1);
    hold("rst_held", 4'hF, 14);
    hold("rst_up", 4'h0, 10);

    // 2. clean press on button 0
    n_p_any = 0;
    hold("press0_a", 4'h1, 5);
    chk("press0_lvl5", btn_level, 4'h0);
    cycle("press0_b", 4'h1);
    chk("press0_pulse", btn_press, 4'h1);
    hold("press0_c", 4'h1, 6);
    chk_int("press0_count", n_p_any, 1);
    hold("press0_rel", 4'h0, 10);

    // 3. bouncing button 1
    n_p1 = 0;
    foreach (r[k]) ;
    hold("bounce", 4'h2, 2);
    hold("bounce", 4'h0, 2);
    hold("bounce", 4'h2, 2);
    hold("bounce", 4'h0, 2);
    hold("bounce", 4'h2, 10);
    chk_int("bounce_one_press", n_p1, 1);
    hold("bounce_rel", 4'h0, 10);

    // 4. release on button 2
    hold("rel2_up", 4'h4, 10);
    n_r2 = 0;
    n_p_any = 0;
    hold("rel2_a", 4'h0, 5);
    chk("rel2_lvl5", btn_level, 4'h4);
    cycle("rel2_b", 4'h0);
    chk("rel2_pulse", btn_release, 4'h4);
    hold("rel2_c", 4'h0, 4);
    chk_int("rel2_count", n_r2, 1);
    chk_int("rel2_nopress", n_p_any, 0);

    // 5. auto-repeat on button 3
    n_rep3 = 0;
    hold("rpt3_hold", 4'h8, 30);
    hold("rpt3_rel", 4'h0, 10);
`ifdef BTN_AUTO_REPEAT_EN
    chk_int("rpt3_count", n_rep3, 8);
`else
    chk_int("rpt3_count", n_rep3, 0);
`endif

    // 6. simultaneous press of 0 and 2, release 0 alone
    hold("sim_a", 4'h5, 5);
    cycle("sim_b", 4'h5);
    chk("sim_press", btn_press, 4'h5);
    hold("sim_c", 4'h5, 6);
    hold("sim_d", 4'h4, 14);
    hold("sim_e", 4'h0, 10);

    // Reset in the middle of a debounce count
    hold("midrst_a", 4'h3, 4);
    assert_reset();
    hold("midrst_b", 4'h3, 2);
    rst_l = 1'b1;
    hold("midrst_c", 4'h3, 12);

    // Random toggling, with one reset in the middle
    r = '0;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
      end
      if (k == 200) begin
        assert_reset();
        hold("rand_rst", r, 2);
        rst_l = 1'b1;
      end
      cycle("rand", r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Conditions the raw board push-buttons before they reach the seven-segment display top and its counter logic. Each button goes through a 2-flop synchronizer, a per-button debounce counter and an edge detector. The block outputs a clean level, one-cycle press and release pulses, and an optional auto-repeat pulse. The downstream display/counter logic uses the pulses as increment/decrement/mode strobes.

Parameters:
N_BTN, 4, number of independent button channels
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a change (10 ms at 50 MHz); must be >= 1
REPEAT_DELAY, 25000000, cycles from the press pulse to the first repeat pulse (0.5 s)
REPEAT_PERIOD, 5000000, cycles between subsequent repeat pulses (0.1 s); must be >= 1

Ports:
clk  input  1  system clock, all logic on rising edge
rst_l  input  1  asynchronous active-low reset
buttons_raw  input  N_BTN  raw active-high button pins, asynchronous to clk
btn_level  output  N_BTN  debounced level, 1 = held
btn_press  output  N_BTN  one-cycle pulse on accepted press
btn_release  output  N_BTN  one-cycle pulse on accepted release
btn_repeat  output  N_BTN  one-cycle auto-repeat pulse while held
any_press  output  1  OR of btn_press, same cycle

Behaviour:
- Reset (rst_l low, asynchronous assert, synchronous-to-clk deassert handled upstream) clears all outputs to 0. It also clears synchronizer flops, debounce counters, repeat counters and FSMs, so every channel returns to UP.
- Synchronizer: two flops per channel; sync output lags buttons_raw by 2 edges.
- Debounce, per channel: counter cnt, width $clog2(DEBOUNCE_CYCLES)+1.
  - If sync == btn_level, cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1, btn_level <= sync and cnt <= 0.
  - Else cnt <= cnt+1.
  - Net latency for a clean edge: btn_level changes exactly 2+DEBOUNCE_CYCLES rising edges after the first edge sampling the new raw value.
  - Any single-cycle glitch back to the old value restarts the count from 0.
- Pulses:
  - btn_press[i] = 1 for exactly the cycle btn_level[i] is first 1. It is registered, coincident with the level change.
  - btn_release[i] behaves the same on the falling level.
  - Press and release never coincide on one channel.
  - Channels are fully independent; simultaneous presses give simultaneous pulses.
- Per-channel FSM, states UP, HOLD_DELAY, HOLD_REPEAT:
  - UP -> HOLD_DELAY on accepted press; the repeat counter rc is loaded to 0.
  - HOLD_DELAY: rc increments each cycle. When rc == REPEAT_DELAY-1: pulse btn_repeat, rc <= 0, go to HOLD_REPEAT.
  - HOLD_REPEAT: when rc == REPEAT_PERIOD-1, pulse btn_repeat and set rc <= 0.
  - Any state -> UP on accepted release, in the same cycle btn_release pulses. No repeat pulse is issued in that cycle.
  - The rc width is sized for max(REPEAT_DELAY, REPEAT_PERIOD).
- Button held through reset release: level starts 0, so the press is accepted after 2+DEBOUNCE_CYCLES cycles and the press pulse is produced.
- Reset mid-count discards all partial debounce and repeat progress.

Optional Feature:
- Macro BTN_AUTO_REPEAT_EN.
- Defined: the HOLD_DELAY/HOLD_REPEAT states and rc counters are built as above.
- Undefined: the FSM reduces to UP/DOWN, the repeat counters are not instantiated, and btn_repeat is driven constant 0. The port is retained so the top-level wiring is identical either way.
- btn_level, btn_press, btn_release and any_press are unaffected by the macro.

Test Plan:
All scenarios use the sim parameters DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3, N_BTN=4, with clk period 20 ns.
1. Reset: hold rst_l=0 with buttons_raw=4'hF for 5 cycles -> all outputs 0 throughout. After release, btn_level=4'hF and btn_press=4'hF with any_press=1 for one cycle, exactly 6 edges later.
2. Clean press: buttons_raw[0] 0->1 and held -> btn_level[0] rises 6 edges after the first sampling edge. btn_press[0] is high exactly 1 cycle and the other bits stay 0.
3. Bounce: buttons_raw[1] toggles 1,0,1,0,1 at 2-cycle intervals, then holds 1 -> exactly one btn_press[1] pulse, 6 edges after the final stable rise. btn_level[1] never glitches.
4. Release: with btn_level[2]=1, drive buttons_raw[2]=0 -> btn_release[2] one-cycle pulse coincident with btn_level[2] falling, 6 edges later. btn_press stays 0.
5. Auto-repeat (macro defined): hold buttons_raw[3] for 30 cycles -> btn_repeat[3] pulses 8 cycles after btn_press[3], then every 3 cycles. The pulses stop on the btn_release[3] cycle. With the macro undefined, btn_repeat stays 4'h0.
6. Simultaneous/independent: press buttons 0 and 2 in the same cycle, then release 0 while 2 is held -> coincident press pulses on bits 0 and 2. btn_release[0] appears alone, and bit 2's level and repeat sequence are unaffected.
